// File: rtl/ddc_out_packer_pkg.sv
// Shared definitions for the DDC output packing stage: sample width,
// packed word width and the I/Q pairing state encoding.
package ddc_out_packer_pkg;

    localparam int FILTERBITWIDTH = 16;
    localparam int PACKWIDTH      = 2 * FILTERBITWIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HAVE_I = 2'd1,
        HAVE_Q = 2'd2
    } pack_state_t;

endpackage

// File: rtl/ddc_sync_fifo.sv
// Register-based synchronous FIFO. Occupancy is tracked by an explicit level
// counter so full/empty never depend on pointer equality. The head word is
// read straight out of the register array, so it holds steady while nothing
// is popped.
module ddc_sync_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int ADDRWIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     head,
    output logic [ADDRWIDTH:0]   level,
    output logic                 full,
    output logic                 empty
);

    localparam logic [ADDRWIDTH:0] FULL_LEVEL = (ADDRWIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [ADDRWIDTH-1:0] wr_ptr;
    logic [ADDRWIDTH-1:0] rd_ptr;
    logic                 do_read;
    logic                 do_write;

    assign full     = (level == FULL_LEVEL);
    assign empty    = (level == '0);
    assign do_read  = rd_en && !empty;
    // A pop in the same cycle frees a slot, so a write into a full FIFO is
    // still accepted when it coincides with a read.
    assign do_write = wr_en && (!full || do_read);
    assign head     = mem[rd_ptr];

    // Storage array; cleared on reset so the head reads as zero when empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else if (do_write) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; the level
    // counter is left alone when a read and a write happen together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_write, do_read})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ddc_out_packer.sv
// Pairs strobed I and Q samples into {I,Q} words, buffers them in a small
// FIFO and presents them downstream with valid/ready. Alignment violations
// and dropped words are reported through sticky flags.
module ddc_out_packer #(
    parameter int FILTERBITWIDTH = 16,
    parameter int FIFODEPTH      = 8,
    parameter int ADDRWIDTH      = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pack_en,
    input  logic                          i_flag,
    input  logic [FILTERBITWIDTH-1:0]     i_data,
    input  logic                          q_flag,
    input  logic [FILTERBITWIDTH-1:0]     q_data,
    input  logic                          out_ready,
    input  logic                          clr_status,
    output logic                          out_valid,
    output logic [2*FILTERBITWIDTH-1:0]   out_data,
    output logic [ADDRWIDTH:0]            fifo_level,
    output logic                          overflow,
    output logic                          align_err
);

    import ddc_out_packer_pkg::*;

    pack_state_t                   state;
    logic [FILTERBITWIDTH-1:0]     held;
    logic [2*FILTERBITWIDTH-1:0]   pack_word;
    logic                          pack_valid;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic                          overflow_set;
    logic                          align_set;

    assign out_valid    = !fifo_empty;
    // The FIFO accepts a write while full only when the head is popped in the
    // same cycle, so that is the one case that does not count as a drop.
    assign overflow_set = pack_valid && fifo_full && !(out_ready && out_valid);
    // A repeated strobe on the side already held, without its partner.
    assign align_set    = pack_en &&
                          (((state == HAVE_I) && i_flag && !q_flag) ||
                           ((state == HAVE_Q) && q_flag && !i_flag));

    // Pairing FSM with held sample and one-cycle pack register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            held       <= '0;
            pack_word  <= '0;
            pack_valid <= 1'b0;
        end else begin
            pack_valid <= 1'b0;
            if (!pack_en) begin
                state <= IDLE;
                held  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_flag && q_flag) begin
                            pack_word  <= {i_data, q_data};
                            pack_valid <= 1'b1;
                        end else if (i_flag) begin
                            held  <= i_data;
                            state <= HAVE_I;
                        end else if (q_flag) begin
                            held  <= q_data;
                            state <= HAVE_Q;
                        end
                    end
                    HAVE_I: begin
                        if (q_flag) begin
                            pack_word  <= {held, q_data};
                            pack_valid <= 1'b1;
                            if (i_flag) begin
                                held <= i_data;
                            end else begin
                                state <= IDLE;
                            end
                        end else if (i_flag) begin
                            held <= i_data;
                        end
                    end
                    HAVE_Q: begin
                        if (i_flag) begin
                            pack_word  <= {i_data, held};
                            pack_valid <= 1'b1;
                            if (q_flag) begin
                                held <= q_data;
                            end else begin
                                state <= IDLE;
                            end
                        end else if (q_flag) begin
                            held <= q_data;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Sticky status flags; a new set event takes priority over a clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            align_err <= 1'b0;
        end else begin
            overflow  <= overflow_set | (overflow  & ~clr_status);
            align_err <= align_set    | (align_err & ~clr_status);
        end
    end

    ddc_sync_fifo #(
        .WIDTH     (2 * FILTERBITWIDTH),
        .DEPTH     (FIFODEPTH),
        .ADDRWIDTH (ADDRWIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (pack_valid),
        .wr_data (pack_word),
        .rd_en   (out_ready),
        .head    (out_data),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: doc/ddc_out_packer.md
# ddc_out_packer

Output packing stage after the I- and Q-path FIR pass-control selectors. Each selector delivers a one-cycle-strobed 16-bit sample. This block pairs the I and Q samples into one 32-bit {I,Q} word and buffers the words in a small FIFO. It presents them to the chip output interface with a valid/ready handshake and reports alignment and overflow errors through sticky flags.

## Interface
- FILTERBITWIDTH, 16, width of each I/Q sample
- FIFODEPTH, 8, FIFO depth in words; must be a power of 2, minimum 2
- ADDRWIDTH, 3, log2(FIFODEPTH)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- pack_en  in  1  1 = pairing enabled; 0 = pairing FSM held in IDLE and no FIFO writes
- i_flag  in  1  one-cycle strobe, I sample valid
- i_data  in  FILTERBITWIDTH  I sample
- q_flag  in  1  one-cycle strobe, Q sample valid
- q_data  in  FILTERBITWIDTH  Q sample
- out_ready  in  1  downstream accepts the head word this cycle
- clr_status  in  1  synchronous clear of both sticky flags
- out_valid  out  1  FIFO non-empty
- out_data  out  2*FILTERBITWIDTH  head word, {I[MSB half], Q[LSB half]}
- fifo_level  out  ADDRWIDTH+1  words currently stored, 0..FIFODEPTH
- overflow  out  1  sticky: a packed word was dropped because the FIFO was full
- align_err  out  1  sticky: I/Q pairing was violated

## Operation
- Pairing FSM states: IDLE, HAVE_I, HAVE_Q. A held sample register stores the unpaired sample.
- IDLE:
  - i&q → emit {i_data,q_data}
  - i only → hold I, go to HAVE_I
  - q only → hold Q, go to HAVE_Q
- HAVE_I:
  - q only → emit {held_I,q_data}, go to IDLE
  - q&i → emit {held_I,q_data}, hold the new i_data, stay in HAVE_I
  - i only → set align_err, replace held I with i_data, stay in HAVE_I
- HAVE_Q: mirror image of HAVE_I; on q only, set align_err and replace held Q.
- When pack_en=0, the FSM goes to IDLE on the next edge and discards any held sample. Strobes are ignored. FIFO contents and sticky flags are retained.
- An emit loads the pack register and sets pack_valid for exactly one cycle. On the next edge the word is written to the FIFO.
- FIFO write while full drops the word and sets overflow. If out_ready and out_valid are high in the same cycle, a slot frees and the write is accepted.
- Read occurs when out_valid&out_ready. Read and write in the same cycle leave fifo_level unchanged.
- The read and write pointers wrap modulo FIFODEPTH. Full/empty are derived from fifo_level, not from pointer equality alone.
- A sticky flag set and clr_status in the same cycle: the set wins.
- No arithmetic is performed; data bits pass through unmodified.

## Timing
- Reset values:
  - FSM IDLE, held sample 0, pack_valid 0
  - pointers 0, fifo_level 0
  - out_valid 0, out_data 0
  - overflow 0, align_err 0
- Latency from a pair-completing strobe at edge N to FIFO write at edge N+1. With an empty FIFO, out_valid=1 and out_data are valid after edge N+1 (2 cycles).
- out_data is the registered head word. It is stable while out_valid=1 and out_ready=0.
- Throughput: one word per cycle sustained (i&q every cycle).
- Reset asserted mid-operation clears all state immediately, including any in-flight pack word. The first strobe after release is treated as from IDLE.

## Structure
- Shared ddc package holds FILTERBITWIDTH, the FSM state encodings (2-bit: IDLE=0, HAVE_I=1, HAVE_Q=2) and a word-packing width constant.
- One sub-module: ddc_sync_fifo, a parameterised FIFODEPTH×(2*FILTERBITWIDTH) register FIFO with level, full and empty outputs and a registered head.
- The top level contains the pairing FSM, pack register and sticky flags.

## Test plan
- Simultaneous strobes: i=0x1234, q=0xABCD at edge N with out_ready=1 → out_valid at N+1, out_data=0x1234ABCD for one cycle, fifo_level returns to 0.
- Staggered pair: i=0x0001 at N, q=0x0002 at N+3 → one word 0x00010002, align_err stays 0.
- Alignment fault: i=0x1111, then i=0x2222, then q=0x3333 → align_err=1, single word 0x22223333. clr_status then clears align_err.
- Fill and overflow: out_ready=0, 9 pairs with FIFODEPTH=8 → fifo_level=8, overflow=1. Draining yields pairs 1–8 in order; pair 9 is absent.
- Full with simultaneous read: FIFO full, out_ready=1 while a new pair is written → overflow stays 0, fifo_level stays 8, the new word appears last.
- Reset mid-stream: hold I (HAVE_I), assert rst for 1 cycle, then q=0x5555 → FSM enters HAVE_Q, no word written, all outputs 0 immediately after reset.
